// File: rtl/completion_merger_if.sv
// Completion bus between the execution channels, the merger and the writeback
// consumer: per-channel completion inputs plus the registered writeback slots.
interface completion_merger_if #(
    parameter int NCH       = 3,
    parameter int NWB       = 2,
    parameter int ROB_W     = 5,
    parameter int PR_ADDR_W = 5,
    parameter int ARCH_W    = 4,
    parameter int DATA_W    = 8
);
    localparam int CHAN_W = $clog2(NCH);

    logic                      flush;
    logic                      wb_hold;
    logic [NCH-1:0]            in_valid;
    logic [NCH-1:0]            in_ready;
    logic [NCH*ROB_W-1:0]      in_rob;
    logic [NCH*PR_ADDR_W-1:0]  in_pdest;
    logic [NCH*ARCH_W-1:0]     in_arch;
    logic [NCH*DATA_W-1:0]     in_data;
    logic [NWB-1:0]            wb_valid;
    logic [NWB*ROB_W-1:0]      wb_rob;
    logic [NWB*PR_ADDR_W-1:0]  wb_pdest;
    logic [NWB*ARCH_W-1:0]     wb_arch;
    logic [NWB*DATA_W-1:0]     wb_data;
    logic [NWB*CHAN_W-1:0]     wb_chan;

    modport master (
        output flush, wb_hold, in_valid, in_rob, in_pdest, in_arch, in_data,
        input  in_ready, wb_valid, wb_rob, wb_pdest, wb_arch, wb_data, wb_chan
    );

    modport slave (
        input  flush, wb_hold, in_valid, in_rob, in_pdest, in_arch, in_data,
        output in_ready, wb_valid, wb_rob, wb_pdest, wb_arch, wb_data, wb_chan
    );
endinterface

// File: rtl/completion_merger.sv
// Buffers completions from NCH channels in per-channel FIFOs and merges them
// round-robin onto NWB registered writeback slots. Define COMPLETION_BYPASS_EN
// to let an empty channel's input go straight to writeback in the same cycle.
module completion_merger #(
    parameter int NCH       = 3,
    parameter int NWB       = 2,
    parameter int DEPTH     = 4,
    parameter int PR_ADDR_W = 5,
    parameter int ROB_W     = 5,
    parameter int ARCH_W    = 4,
    parameter int DATA_W    = 8
) (
    input logic                clk,
    input logic                rst,
    completion_merger_if.slave bus
);
    localparam int CHAN_W = $clog2(NCH);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ENT_W  = ROB_W + PR_ADDR_W + ARCH_W + DATA_W;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [ENT_W-1:0]  mem        [NCH][DEPTH];
    logic [PTR_W-1:0]  rd_ptr     [NCH];
    logic [PTR_W-1:0]  wr_ptr     [NCH];
    logic [PTR_W:0]    count      [NCH];
    logic [ENT_W-1:0]  in_entry   [NCH];
    logic [ENT_W-1:0]  head_entry [NCH];
    logic [NCH-1:0]    head_valid;
    logic [NCH-1:0]    bypass;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    push;
    logic [NCH-1:0]    pop;
    logic [CHAN_W-1:0] rr;
    logic [CHAN_W-1:0] rr_next;

    logic [NWB-1:0]    slot_valid;
    logic [CHAN_W-1:0] slot_chan  [NWB];
    logic [NWB-1:0]    wb_valid_q;
    logic [ENT_W-1:0]  wb_entry_q [NWB];
    logic [CHAN_W-1:0] wb_chan_q  [NWB];

    // Ready looks only at the registered count, so a full FIFO never pops through.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            in_entry[c] = {bus.in_rob[c*ROB_W +: ROB_W],
                           bus.in_pdest[c*PR_ADDR_W +: PR_ADDR_W],
                           bus.in_arch[c*ARCH_W +: ARCH_W],
                           bus.in_data[c*DATA_W +: DATA_W]};
            bus.in_ready[c] = (count[c] != FULL);
`ifdef COMPLETION_BYPASS_EN
            bypass[c] = (count[c] == '0) && bus.in_valid[c];
`else
            bypass[c] = 1'b0;
`endif
            head_valid[c] = (count[c] != '0) || bypass[c];
            head_entry[c] = bypass[c] ? in_entry[c] : mem[c][rd_ptr[c]];
        end
    end

    // Scan from rr, granting non-empty heads into slots 0,1,... until NWB are used.
    always_comb begin
        int n;
        int ch;
        logic [CHAN_W-1:0] ch_idx;
        n       = 0;
        ch      = 0;
        ch_idx  = '0;
        grant   = '0;
        slot_valid = '0;
        rr_next = rr;
        for (int k = 0; k < NWB; k++) slot_chan[k] = '0;
        if (!bus.flush && !bus.wb_hold) begin
            for (int i = 0; i < NCH; i++) begin
                ch = int'(rr) + i;
                if (ch >= NCH) ch = ch - NCH;
                ch_idx = CHAN_W'(ch);
                if (n < NWB && head_valid[ch_idx]) begin
                    grant[ch_idx] = 1'b1;
                    for (int k = 0; k < NWB; k++) begin
                        if (k == n) begin
                            slot_valid[k] = 1'b1;
                            slot_chan[k]  = ch_idx;
                        end
                    end
                    rr_next = (ch == NCH - 1) ? '0 : CHAN_W'(ch + 1);
                    n = n + 1;
                end
            end
        end
    end

    // A granted bypass entry never touches its FIFO.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            push[c] = bus.in_valid[c] && bus.in_ready[c] && !bus.flush
                      && !(bypass[c] && grant[c]);
            pop[c]  = grant[c] && !bypass[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= in_entry[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= '0;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else if (bus.flush) begin
            rr <= '0;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            rr <= rr_next;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr[c] <= rd_ptr[c] + PTR_W'(pop[c]);
                wr_ptr[c] <= wr_ptr[c] + PTR_W'(push[c]);
                count[c]  <= count[c] + (PTR_W+1)'(push[c]) - (PTR_W+1)'(pop[c]);
            end
        end
    end

    // Idle slots keep their old payload; only the valid bit drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q <= '0;
            for (int k = 0; k < NWB; k++) begin
                wb_entry_q[k] <= '0;
                wb_chan_q[k]  <= '0;
            end
        end else begin
            wb_valid_q <= slot_valid;
            for (int k = 0; k < NWB; k++) begin
                if (slot_valid[k]) begin
                    wb_entry_q[k] <= head_entry[slot_chan[k]];
                    wb_chan_q[k]  <= slot_chan[k];
                end
            end
        end
    end

    always_comb begin
        bus.wb_valid = wb_valid_q;
        for (int k = 0; k < NWB; k++) begin
            bus.wb_rob[k*ROB_W +: ROB_W]           = wb_entry_q[k][ENT_W-1 -: ROB_W];
            bus.wb_pdest[k*PR_ADDR_W +: PR_ADDR_W] = wb_entry_q[k][DATA_W+ARCH_W +: PR_ADDR_W];
            bus.wb_arch[k*ARCH_W +: ARCH_W]        = wb_entry_q[k][DATA_W +: ARCH_W];
            bus.wb_data[k*DATA_W +: DATA_W]        = wb_entry_q[k][0 +: DATA_W];
            bus.wb_chan[k*CHAN_W +: CHAN_W]        = wb_chan_q[k];
        end
    end
endmodule

// File: tb/tb_completion_merger.sv
// Directed bench for completion_merger: reset, single completion, contention,
// back-pressure, flush and (when COMPLETION_BYPASS_EN is defined) bypass latency.
module tb_completion_merger;
    localparam int NCH       = 3;
    localparam int NWB       = 2;
    localparam int DEPTH     = 4;
    localparam int PR_ADDR_W = 5;
    localparam int ROB_W     = 5;
    localparam int ARCH_W    = 4;
    localparam int DATA_W    = 8;
    localparam int CHAN_W    = $clog2(NCH);
`ifdef COMPLETION_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    completion_merger_if #(.NCH(NCH), .NWB(NWB), .ROB_W(ROB_W), .PR_ADDR_W(PR_ADDR_W),
                           .ARCH_W(ARCH_W), .DATA_W(DATA_W)) bus ();

    completion_merger #(.NCH(NCH), .NWB(NWB), .DEPTH(DEPTH), .PR_ADDR_W(PR_ADDR_W),
                        .ROB_W(ROB_W), .ARCH_W(ARCH_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int c, input logic v, input int rob, input int pdest,
                                 input int arch, input int data);
        bus.in_valid[c]                       = v;
        bus.in_rob[c*ROB_W +: ROB_W]          = ROB_W'(rob);
        bus.in_pdest[c*PR_ADDR_W +: PR_ADDR_W] = PR_ADDR_W'(pdest);
        bus.in_arch[c*ARCH_W +: ARCH_W]       = ARCH_W'(arch);
        bus.in_data[c*DATA_W +: DATA_W]       = DATA_W'(data);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wbRob(input int k);
        return 32'(bus.wb_rob[k*ROB_W +: ROB_W]);
    endfunction

    function automatic logic [31:0] wbChan(input int k);
        return 32'(bus.wb_chan[k*CHAN_W +: CHAN_W]);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic readyBefore;
        int   nextRob;

        bus.flush    = 1'b0;
        bus.wb_hold  = 1'b0;
        bus.in_valid = '0;
        bus.in_rob   = '0;
        bus.in_pdest = '0;
        bus.in_arch  = '0;
        bus.in_data  = '0;

        // Reset held with every channel offering an entry
        for (int c = 0; c < NCH; c++) applyStimulus(c, 1'b1, 3, 3, 3, 3);
        repeat (3) tick();
        checkOutput("reset_wb_valid", 32'(bus.wb_valid), 32'h0);
        checkOutput("reset_wb_rob", 32'(bus.wb_rob), 32'h0);
        checkOutput("reset_wb_data", 32'(bus.wb_data), 32'h0);
        checkOutput("reset_wb_chan", 32'(bus.wb_chan), 32'h0);
        bus.in_valid = '0;
        rst = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'h7);
        tick();
        tick();
        checkOutput("no_write_in_reset", 32'(bus.wb_valid), 32'h0);

        // Single completion on channel 1
        applyStimulus(1, 1'b1, 5, 9, 1, 'hA5);
        tick();
        bus.in_valid = '0;
        checkOutput("single_after_push_edge", 32'(bus.wb_valid), (LAT == 0) ? 32'h1 : 32'h0);
        repeat (LAT) tick();
        checkOutput("single_valid", 32'(bus.wb_valid), 32'h1);
        checkOutput("single_rob", wbRob(0), 32'd5);
        checkOutput("single_pdest", 32'(bus.wb_pdest[0 +: PR_ADDR_W]), 32'd9);
        checkOutput("single_arch", 32'(bus.wb_arch[0 +: ARCH_W]), 32'h1);
        checkOutput("single_data", 32'(bus.wb_data[0 +: DATA_W]), 32'hA5);
        checkOutput("single_chan", wbChan(0), 32'd1);
        tick();
        checkOutput("single_next_idle", 32'(bus.wb_valid), 32'h0);

        // Flush pulse with nothing buffered returns rr to 0
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;

        // Contention: all three channels push at once
        applyStimulus(0, 1'b1, 1, 10, 2, 'h30);
        applyStimulus(1, 1'b1, 2, 11, 2, 'h31);
        applyStimulus(2, 1'b1, 3, 12, 2, 'h32);
        tick();
        bus.in_valid = '0;
        repeat (LAT) tick();
        checkOutput("cont1_valid", 32'(bus.wb_valid), 32'h3);
        checkOutput("cont1_rob0", wbRob(0), 32'd1);
        checkOutput("cont1_chan0", wbChan(0), 32'd0);
        checkOutput("cont1_rob1", wbRob(1), 32'd2);
        checkOutput("cont1_chan1", wbChan(1), 32'd1);
        tick();
        checkOutput("cont2_valid", 32'(bus.wb_valid), 32'h1);
        checkOutput("cont2_rob0", wbRob(0), 32'd3);
        checkOutput("cont2_chan0", wbChan(0), 32'd2);
        checkOutput("cont2_slot1_kept", wbRob(1), 32'd2);
        tick();
        checkOutput("cont3_idle", 32'(bus.wb_valid), 32'h0);

        // rr is back at 0: ch0 must win slot 0 over ch2
        applyStimulus(0, 1'b1, 4, 1, 1, 'h40);
        applyStimulus(2, 1'b1, 6, 2, 1, 'h42);
        tick();
        bus.in_valid = '0;
        repeat (LAT) tick();
        checkOutput("rr0_valid", 32'(bus.wb_valid), 32'h3);
        checkOutput("rr0_chan0", wbChan(0), 32'd0);
        checkOutput("rr0_rob0", wbRob(0), 32'd4);
        checkOutput("rr0_chan1", wbChan(1), 32'd2);
        checkOutput("rr0_rob1", wbRob(1), 32'd6);
        tick();

        // Back-pressure: fill ch0 under wb_hold
        bus.wb_hold = 1'b1;
        for (int r = 0; r < 4; r++) begin
            applyStimulus(0, 1'b1, r, r, 1, r);
            checkOutput("bp_ready_before_push", 32'(bus.in_ready[0]), 32'h1);
            tick();
            checkOutput("bp_hold_idle", 32'(bus.wb_valid), 32'h0);
        end
        checkOutput("bp_full", 32'(bus.in_ready[0]), 32'h0);
        applyStimulus(0, 1'b1, 4, 4, 1, 4);
        tick();
        checkOutput("bp_still_full", 32'(bus.in_ready[0]), 32'h0);
        checkOutput("bp_still_idle", 32'(bus.wb_valid), 32'h0);
        bus.wb_hold = 1'b0;
        nextRob = 4;
        checkOutput("bp_full_while_pop", 32'(bus.in_ready[0]), 32'h0);
        for (int i = 0; i < 6; i++) begin
            readyBefore = bus.in_ready[0];
            tick();
            checkOutput("bp_drain_valid", 32'(bus.wb_valid), 32'h1);
            checkOutput("bp_drain_rob", wbRob(0), 32'(i));
            checkOutput("bp_drain_chan", wbChan(0), 32'd0);
            if (readyBefore && bus.in_valid[0]) begin
                nextRob++;
                if (nextRob == 6) bus.in_valid[0] = 1'b0;
                else applyStimulus(0, 1'b1, nextRob, nextRob, 1, nextRob);
            end
        end
        tick();
        checkOutput("bp_drained", 32'(bus.wb_valid), 32'h0);

        // Flush with two entries buffered per channel and ch2 pushing
        bus.wb_hold = 1'b1;
        for (int c = 0; c < NCH; c++) applyStimulus(c, 1'b1, 10 + c, c, 1, 'h50 + c);
        tick();
        for (int c = 0; c < NCH; c++) applyStimulus(c, 1'b1, 13 + c, c, 1, 'h60 + c);
        tick();
        bus.in_valid = '0;
        checkOutput("flush_prefill_idle", 32'(bus.wb_valid), 32'h0);
        bus.wb_hold = 1'b0;
        bus.flush   = 1'b1;
        applyStimulus(2, 1'b1, 20, 7, 1, 'h70);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = '0;
        checkOutput("flush_wb_valid", 32'(bus.wb_valid), 32'h0);
        checkOutput("flush_ready", 32'(bus.in_ready), 32'h7);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("flush_no_stale", 32'(bus.wb_valid), 32'h0);
        end
        applyStimulus(0, 1'b1, 21, 3, 1, 'h71);
        applyStimulus(2, 1'b1, 22, 4, 1, 'h72);
        tick();
        bus.in_valid = '0;
        repeat (LAT) tick();
        checkOutput("flush_rr_valid", 32'(bus.wb_valid), 32'h3);
        checkOutput("flush_rr_chan0", wbChan(0), 32'd0);
        checkOutput("flush_rr_rob0", wbRob(0), 32'd21);
        checkOutput("flush_rr_chan1", wbChan(1), 32'd2);
        checkOutput("flush_rr_rob1", wbRob(1), 32'd22);
        tick();
        checkOutput("final_idle", 32'(bus.wb_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
